// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory responder.
//   state_t        : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W / BE_W  : data word width and byte-enable width
//   CNT_W          : width of the wait-state counter (WAIT_STATES is 0..15)
//   dmem_offset    : byte offset of an address relative to the window base
//   dmem_in_range  : true when a byte offset falls inside a DEPTH-word window
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Offset wraps on underflow (address below the base), so a single unsigned
  // compare against the window size also rejects addresses below the base.
  function automatic logic [WORD_W-1:0] dmem_offset(input logic [WORD_W-1:0] addr,
                                                    input logic [WORD_W-1:0] base);
    return addr - base;
  endfunction

  // Compared in 34 bits so DEPTH*4 cannot overflow the 32-bit address space.
  function automatic logic dmem_in_range(input logic [WORD_W-1:0] offset,
                                         input int unsigned       depth);
    logic [WORD_W+1:0] limit;
    limit = {2'b00, depth} << 2;
    return ({2'b00, offset} < limit);
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// -----------------------------------------------------------------------------
// dmem_sram
// Single-port synchronous SRAM, DEPTH x 32 bits, per-byte write enable and a
// registered read port. A read updates o_rdata only on an enabled read cycle,
// so the output holds its value until the next enabled read.
// Ports:
//   clk      in   clock, rising edge
//   i_en     in   access enable for this cycle
//   i_we     in   1 = write selected lanes, 0 = read word into o_rdata
//   i_be     in   byte-lane write enables (lane i = bits [8i+7:8i])
//   i_addr   in   word index
//   i_wdata  in   write data
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module dmem_sram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [BE_W-1:0]          i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WORD_W-1:0]        i_wdata,
  output logic [WORD_W-1:0]        o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // NOTE: the array and its read register have no reset on purpose; a reset
  // term would stop the array mapping onto an SRAM macro or block RAM.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side end of the pipeline's load/store port. Accepts one request at a
// time, waits WAIT_STATES cycles, then commits a byte-enabled write or reads a
// word, and holds the response until the requester takes it.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  responder can accept (IDLE and not in reset)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data
//   req_be     in   byte enables (writes only)
//   rsp_valid  out  response present
//   rsp_ready  in   requester takes the response
//   rsp_rdata  out  read data; 0 for writes and errors
//   rsp_err    out  request rejected, storage unchanged
// Configuration macro:
//   DMEM_MISALIGN_CHECK_EN  when defined, addresses with addr[1:0] != 0 are
//                           rejected with rsp_err; otherwise the low two bits
//                           are ignored and the containing word is accessed.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned       DEPTH       = 1024,
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [WORD_W-1:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  // FSM, counter and request latches
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;

  // Response registers; r_rsp_rd marks a successful read so the SRAM read
  // register is passed through, otherwise the data output is forced to 0.
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              r_rsp_rd;

  logic              w_accept;
  logic              w_commit;
  logic              w_c_we;
  logic [WORD_W-1:0] w_c_addr;
  logic [WORD_W-1:0] w_c_wdata;
  logic [BE_W-1:0]   w_c_be;
  logic [WORD_W-1:0] w_c_offset;
  logic [AW-1:0]     w_c_index;
  logic              w_misalign;
  logic              w_c_err;
  logic              w_sram_en;
  logic [WORD_W-1:0] w_sram_rdata;

  assign req_ready = !rst && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;

  // The commit happens on the edge that enters RESP. With no wait states that
  // is the accept edge itself, so the live request fields are used; otherwise
  // the latched copy is used on the last WAIT cycle.
  // NOTE: every signal assigned here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    if (WAIT_STATES == 0) begin
      w_commit  = w_accept;
      w_c_we    = req_we;
      w_c_addr  = req_addr;
      w_c_wdata = req_wdata;
      w_c_be    = req_be;
    end else begin
      w_commit  = (r_state == WAIT) && (r_cnt == CNT_W'(1));
      w_c_we    = r_we;
      w_c_addr  = r_addr;
      w_c_wdata = r_wdata;
      w_c_be    = r_be;
    end
  end

  // Address decode and rejection
  assign w_c_offset = dmem_offset(w_c_addr, ADDR_BASE);
  assign w_c_index  = w_c_offset[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = |w_c_addr[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_c_err   = !dmem_in_range(w_c_offset, DEPTH) || w_misalign;

  // Rejected requests never touch the array, so the read register keeps
  // whatever it held and the output mux reports 0.
  assign w_sram_en = w_commit && !w_c_err;

  dmem_sram #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_sram_en),
    .i_we    (w_c_we),
    .i_be    (w_c_be),
    .i_addr  (w_c_index),
    .i_wdata (w_c_wdata),
    .o_rdata (w_sram_rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rd    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            if (WAIT_STATES == 0) begin
              r_state <= RESP;
            end else begin
              r_cnt   <= CNT_W'(WAIT_STATES);
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= RESP;
        end
        RESP: begin
          // Response retires here; req_ready rises only on the next cycle.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rd    <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_commit) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_c_err;
        r_rsp_rd    <= !w_c_we && !w_c_err;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rd ? w_sram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder with randomized traffic checked
// against a word-array reference model. Honors DMEM_MISALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WS    = 3;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] SPAN  = DEPTH * 4;
  localparam int          BOUND = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS),
    .ADDR_BASE   (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Reference model: a plain word array addressed by (addr - BASE) / 4.
  task automatic model_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              output logic [31:0] rd, output logic err);
    logic [31:0] off;
    int unsigned idx;
    off = addr - BASE;
    err = (off >= SPAN);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (addr % 4 != 0) err = 1'b1;
`endif
    rd = 32'h0;
    if (!err) begin
      idx = off / 4;
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        rd = model_mem[idx];
      end
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    int n;
    n = 0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    // Scramble inputs while busy; the responder must ignore them.
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
  endtask

  // Called at the negedge after accept; waits for, holds and retires a response.
  task automatic collect(input string name, input int hold,
                         input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    logic [31:0] rd0;
    logic e0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (rsp_valid !== 1'b1 || lat != 1 + WS) begin
      n_err++;
      $display("FAIL %s latency: edges=%0d valid=%b required %0d", name, lat, rsp_valid, 1 + WS);
    end
    n_chk++;
    if (rsp_rdata !== exp_rd) begin
      n_err++;
      $display("FAIL %s rdata: got %h required %h", name, rsp_rdata, exp_rd);
    end
    n_chk++;
    if (rsp_err !== exp_err) begin
      n_err++;
      $display("FAIL %s err: got %b required %b", name, rsp_err, exp_err);
    end
    rd0 = rsp_rdata;
    e0  = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || rsp_err !== e0 || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b req_ready=%b required 1/%h/%b/0",
                 name, i, rsp_valid, rsp_rdata, rsp_err, req_ready, rd0, e0);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s retire: valid=%b rdata=%h err=%b req_ready=%b required 0/0/0/1",
               name, rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
  endtask

  task automatic xact(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int hold);
    logic [31:0] rd;
    logic err;
    model_access(we, addr, wdata, be, rd, err);
    send(we, addr, wdata, be);
    collect(name, hold, rd, err);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_assert: valid=%b ready=%b rdata=%h err=%b required 0/0/0/0",
               rsp_valid, req_ready, rsp_rdata, rsp_err);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held: req_ready=%b required 0", req_ready);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: req_ready=%b valid=%b required 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++)
      xact("fill", 1'b1, BASE + 4 * i, $urandom, 4'hF, 0);
  endtask

  task automatic test_basic();
    xact("wr_deadbeef", 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0);
    xact("rd_deadbeef", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 0);
  endtask

  task automatic test_byte_enable();
    xact("wr_be2", 1'b1, BASE + 32'h10, 32'h0000AA00, 4'b0010, 0);
    xact("rd_be2", 1'b0, BASE + 32'h10, 32'h0, 4'hF, 0);
    xact("wr_be0", 1'b1, BASE + 32'h10, 32'h11223344, 4'b0000, 0);
    xact("rd_be0", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd_a, rd_b;
    logic err_a, err_b;
    model_access(1'b1, BASE + 32'h40, 32'hCAFE0001, 4'hF, rd_a, err_a);
    model_access(1'b0, BASE + 32'h40, 32'h0, 4'h0, rd_b, err_b);
    send(1'b1, BASE + 32'h40, 32'hCAFE0001, 4'hF);
    // Second request pending while the first response is held for 5 cycles.
    req_we = 1'b0; req_addr = BASE + 32'h40; req_wdata = 32'h0; req_be = 4'h0;
    req_valid = 1'b1;
    collect("b2b_first", 5, rd_a, err_a);
    @(negedge clk);
    req_valid = 1'b0;
    n_chk++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second_accept: req_ready=%b required 0", req_ready);
    end
    collect("b2b_second", 0, rd_b, err_b);
  endtask

  task automatic test_range();
    xact("wr_past_end", 1'b1, BASE + SPAN, 32'h12345678, 4'hF, 0);
    xact("rd_word0", 1'b0, BASE, 32'h0, 4'h0, 0);
    xact("wr_below_base", 1'b1, BASE - 32'h4, 32'h12345678, 4'hF, 0);
    xact("rd_past_end", 1'b0, BASE + SPAN + 32'h20, 32'h0, 4'h0, 0);
    xact("rd_last_word", 1'b0, BASE + SPAN - 32'h4, 32'h0, 4'h0, 0);
    xact("rd_word0_again", 1'b0, BASE, 32'h0, 4'h0, 0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic err;
    int n;
    // Write interrupted in WAIT: dropped, old value kept.
    send(1'b1, BASE + 32'h20, 32'hBAD0BAD0, 4'hF);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_in_wait: valid=%b ready=%b required 0/0", rsp_valid, req_ready);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    xact("rd_after_drop", 1'b0, BASE + 32'h20, 32'h0, 4'h0, 0);
    // Reset while a read response is held: outputs clear at once.
    model_access(1'b0, BASE + 32'h24, 32'h0, 4'h0, rd, err);
    send(1'b0, BASE + 32'h24, 32'h0, 4'h0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (rsp_rdata !== rd) begin
      n_err++;
      $display("FAIL rd_before_rst: got %h required %h", rsp_rdata, rd);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_in_resp: valid=%b rdata=%h err=%b required 0/0/0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misalign();
    xact("rd_misaligned", 1'b0, BASE + 32'h11, 32'h0, 4'h0, 0);
    xact("wr_misaligned", 1'b1, BASE + 32'h32, 32'h5A5A5A5A, 4'hF, 0);
    xact("rd_after_mis_wr", 1'b0, BASE + 32'h30, 32'h0, 4'h0, 0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0:       addr = BASE + SPAN + $urandom_range(0, 64);
        1:       addr = BASE - $urandom_range(1, 64);
        2:       addr = $urandom;
        default: addr = BASE + $urandom_range(0, SPAN - 1);
      endcase
      xact("random", 1'($urandom), addr, $urandom, 4'($urandom), $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    test_reset();
    test_fill();
    test_basic();
    test_byte_enable();
    test_back_to_back();
    test_range();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
